// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module  : hazard_scoreboard
// Brief   : Tracks in-flight write-back metadata from EXE to WB; flags ID
//           hazards and returns per-source forwarding selects.
// Rev     : 1.0  initial release
// ============================================================================
module hazard_scoreboard #(
    parameter int REG_NUM_BITS   = 4,
    parameter int PIPE_DEPTH     = 3,
    parameter int LOAD_FWD_STAGE = 2,
    parameter int SEL_W          = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    issue_valid,
    input  logic                    issue_wb_en,
    input  logic                    issue_mem_r_en,
    input  logic [REG_NUM_BITS-1:0] issue_dest,
    input  logic [REG_NUM_BITS-1:0] src1,
    input  logic [REG_NUM_BITS-1:0] src2,
    input  logic                    two_src,
    input  logic                    forward_en,
    input  logic                    flush,
    input  logic                    pipe_stall,
    output logic                    hazard,
    output logic [SEL_W-1:0]        sel_src1,
    output logic [SEL_W-1:0]        sel_src2,
    output logic [15:0]             stall_count
);

    localparam logic [SEL_W-1:0] c_wb_stage       = SEL_W'(PIPE_DEPTH);
    localparam logic [SEL_W-1:0] c_load_fwd_stage = SEL_W'(LOAD_FWD_STAGE);
    localparam logic [15:0]      c_count_max      = 16'hFFFF;

    logic [PIPE_DEPTH:1]     r_valid;
    logic [PIPE_DEPTH:1]     r_wb_en;
    logic [PIPE_DEPTH:1]     r_mem_r_en;
    logic [REG_NUM_BITS-1:0] r_dest [1:PIPE_DEPTH];
    logic [15:0]             r_stall_count;

    logic [REG_NUM_BITS-1:0] w_src       [0:1];
    logic [SEL_W-1:0]        w_src_sel   [0:1];
    logic [1:0]              w_src_hazard;
    logic                    w_hazard;
    logic                    w_accept;

    assign w_src[0] = src1;
    assign w_src[1] = src2;

    generate
        for (genvar s = 0; s < 2; s++) begin : g_src
            logic             w_found;
            logic             w_is_load;
            logic [SEL_W-1:0] w_idx;
            logic             w_haz;

            // Scan oldest to youngest so the youngest producer overrides (WAW).
            always_comb begin
                w_found   = 1'b0;
                w_is_load = 1'b0;
                w_idx     = '0;
                for (int k = PIPE_DEPTH; k >= 1; k--) begin
                    if (r_valid[k] && r_wb_en[k] && (r_dest[k] == w_src[s])) begin
                        w_found   = 1'b1;
                        w_is_load = r_mem_r_en[k];
                        w_idx     = SEL_W'(k);
                    end
                end
            end

            // WB-stage matches are safe without forwarding: the register file
            // writes on the falling edge, ahead of the ID read.
            assign w_haz = forward_en ? (w_found && w_is_load && (w_idx < c_load_fwd_stage))
                                      : (w_found && (w_idx < c_wb_stage));

            assign w_src_hazard[s] = w_haz;
            assign w_src_sel[s]    = (forward_en && w_found && !w_haz) ? w_idx : '0;
        end
    endgenerate

    assign w_hazard = issue_valid && (w_src_hazard[0] || (two_src && w_src_hazard[1]));
    assign w_accept = issue_valid && !w_hazard && !flush && !pipe_stall;

    assign hazard      = w_hazard;
    assign sel_src1    = (issue_valid && !w_hazard) ? w_src_sel[0] : '0;
    assign sel_src2    = (issue_valid && !w_hazard && two_src) ? w_src_sel[1] : '0;
    assign stall_count = r_stall_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid    <= '0;
            r_wb_en    <= '0;
            r_mem_r_en <= '0;
            for (int k = 1; k <= PIPE_DEPTH; k++) begin
                r_dest[k] <= '0;
            end
        end else if (!pipe_stall) begin
            for (int k = PIPE_DEPTH; k >= 2; k--) begin
                r_valid[k]    <= r_valid[k-1];
                r_wb_en[k]    <= r_wb_en[k-1];
                r_mem_r_en[k] <= r_mem_r_en[k-1];
                r_dest[k]     <= r_dest[k-1];
            end
            // A rejected, stalled or flushed ID slot enters EXE as a bubble.
            r_valid[1]    <= w_accept;
            r_wb_en[1]    <= w_accept && issue_wb_en;
            r_mem_r_en[1] <= w_accept && issue_mem_r_en;
            r_dest[1]     <= w_accept ? issue_dest : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_count <= '0;
        end else if (w_hazard && !flush && !pipe_stall && (r_stall_count != c_count_max)) begin
            r_stall_count <= r_stall_count + 16'd1;
        end
    end

endmodule
`default_nettype wire

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised hazard detection and forwarding-select unit for the pipelined ARM core.
- Keeps a shadow shift register of write-back metadata for every stage from EXE to WB, with configurable depth.
- Compares ID-stage source registers against every in-flight destination. It asserts a stall on unresolvable hazards, otherwise returns a per-source forwarding select.
- Generalises the fixed EXE/MEM hazard and forwarding pair. New behaviour: arbitrary depth, load-use latency, back-end freeze, flush bubbles, saturating stall counter.

Parameters:
- REG_NUM_BITS, 4, register index width.
- PIPE_DEPTH, 3, tracked stages after ID (stage 1 = EXE … stage PIPE_DEPTH = WB); legal range 2..8.
- LOAD_FWD_STAGE, 2, first stage from which a load result is forwardable (2..PIPE_DEPTH).
- SEL_W, 2, select width; must satisfy 2**SEL_W > PIPE_DEPTH.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- issue_valid  in  1  a valid instruction occupies ID.
- issue_wb_en  in  1  ID instruction writes a register.
- issue_mem_r_en  in  1  ID instruction is a load.
- issue_dest  in  REG_NUM_BITS  ID destination register.
- src1  in  REG_NUM_BITS  first source (always used when issue_valid).
- src2  in  REG_NUM_BITS  second source, used only when two_src=1.
- two_src  in  1  src2 is live.
- forward_en  in  1  forwarding enabled.
- flush  in  1  branch taken in EXE; kills the ID instruction.
- pipe_stall  in  1  back-end freeze; all tracked stages hold.
- hazard  out  1  ID must stall (combinational).
- sel_src1  out  SEL_W  0 = register file, k = forward from stage k.
- sel_src2  out  SEL_W  same, for src2; 0 when two_src=0.
- stall_count  out  16  saturating count of hazard-stall cycles.

Behaviour:
- Storage: per stage k, entry {valid, wb_en, mem_r_en, dest}.
- Reset (async, rst=1): all entries valid=0 and stall_count=0. Hence hazard=0 and sel_src1=sel_src2=0 while in reset.
- Accept condition: accept = issue_valid & ~hazard & ~flush & ~pipe_stall.
- Shift, each rising edge with pipe_stall=0:
  - stage[k+1] <= stage[k] for k = 1..PIPE_DEPTH-1.
  - stage[1] <= ID fields with valid=1 if accept, else a bubble (valid=0).
  - The stage[PIPE_DEPTH] entry retires.
- pipe_stall=1: every entry holds. Flush and issue are ignored that cycle and no bubble is inserted.
- Match for a live source s: stage k with valid & wb_en & dest==s. The youngest match (smallest k) wins. Older matches are shadowed by WAW ordering.
- forward_en=0:
  - Hazard if any live source matches in stages 1..PIPE_DEPTH-1.
  - A match in stage PIPE_DEPTH is not a hazard, because the register file writes on the falling edge.
  - Selects are 0.
- forward_en=1, per source:
  - No match: sel=0.
  - Youngest match is a load with k < LOAD_FWD_STAGE: hazard, sel=0.
  - Otherwise sel=k, no hazard from that source.
- hazard = issue_valid & (hazard(src1) | (two_src & hazard(src2))). It is purely combinational, evaluated regardless of flush and pipe_stall.
- Selects are combinational and valid only when issue_valid=1 and hazard=0. Otherwise they are driven to 0.
- Register 0 gets no special treatment; all 2**REG_NUM_BITS indices are tracked.
- Simultaneous flush and hazard: flush wins; a bubble is inserted and stall_count is not incremented.
- stall_count increments by 1 on each edge where issue_valid & hazard & ~flush & ~pipe_stall. It holds at 16'hFFFF (no wrap).
- Reset asserted mid-operation clears all entries immediately, without waiting for a clock edge.
- Latency: an accepted producer becomes visible to the next ID instruction exactly one cycle later, at stage 1.

Test Plan:
- Defaults, forward_en=1:
  - Stimulus: issue ADD r3 (wb_en=1); next cycle issue src1=r3.
  - Required: hazard=0, sel_src1=1.
  - Continue: one cycle later issue src1=r3 again → sel_src1=2.
- LDR to r5 then immediate src2=r5, two_src=1:
  - Required: hazard=1 for one cycle and stall_count 0→1.
  - Next cycle: hazard=0, sel_src2=2.
- forward_en=0, ADD r4 then src1=r4:
  - Required: hazard=1 for 2 cycles (stages 1 and 2), then hazard=0 with sel_src1=0 when the producer is in stage 3.
- WAW: issue r7, then r7 again, then src1=r7.
  - Required: sel_src1=1 (youngest producer), not 2.
- pipe_stall=1 for 3 cycles while a producer r2 sits in stage 1 and ID holds src1=r2 (load):
  - Required: entries frozen, hazard=1, stall_count unchanged.
  - After release: one counted stall, then sel_src1=2.
- Flush and reset:
  - flush=1 with ID hazard → stall_count not incremented, stage 1 bubble.
  - Force stall_count to 16'hFFFF and cause a hazard → stays 16'hFFFF.
  - Assert rst between edges → hazard drops to 0 immediately.
